aes_tx_shifter: RTL and testbench
=================================

Name: aes_tx_shifter

Overview:
Transmit-side block for the AES accelerator. It captures each finished 128-bit result block from the AES control block's Tx_SR output when load_enable pulses. It then streams the block out byte by byte over a valid/ready interface to the host-side link, starting with the most significant byte. A one-deep holding register lets the next block arrive while the current one is still being sent.

Parameters:
BLOCK_W, 128, width of the result block; must be a multiple of BYTE_W
BYTE_W, 8, width of one output beat
BEATS, BLOCK_W/BYTE_W (16), beats per block; derived, not overridable

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
load_enable  input  1  one-cycle strobe: Tx_SR holds a valid result block
Tx_SR  input  BLOCK_W  result block from the AES control block
tx_ready  input  1  downstream accepts the current beat
clear_ovf  input  1  synchronous clear of the overflow flag
tx_data  output  BYTE_W  current output byte
tx_valid  output  1  tx_data is valid
tx_last  output  1  marks beat BEATS-1 of a block
block_done  output  1  one-cycle pulse after the last beat of a block is accepted
busy  output  1  shifter or holding register occupied
overflow  output  1  sticky flag: a block was dropped

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; shifter, holding register and beat counter cleared. tx_data=0, tx_valid=0, tx_last=0, block_done=0, busy=0, overflow=0.
- Reset asserted mid-block: the block is discarded and no block_done is produced.
- FSM has two states.
  - IDLE: tx_valid=0. On load_enable, Tx_SR loads into the shifter, beat counter=0, and the FSM goes to SEND. tx_valid is high in the cycle after the load edge (1-cycle latency).
  - SEND: tx_valid=1 and tx_data=shifter[BLOCK_W-1 -: BYTE_W].
    - A beat is accepted when tx_valid && tx_ready at a rising edge. On acceptance the shifter shifts left by BYTE_W (zero fill) and the counter increments.
    - tx_last=1 when counter==BEATS-1.
- Stall: while tx_valid && !tx_ready, tx_data, tx_last and the counter are held stable.
- Last beat accepted:
  - block_done pulses high in the next cycle.
  - If the holding register is full, its contents move into the shifter, the counter resets to 0 and the FSM stays in SEND. There is no bubble: beat 0 of the next block is valid in the next cycle.
  - Else, if load_enable is high in that same cycle, Tx_SR loads directly into the shifter and the FSM stays in SEND.
  - Else the FSM goes to IDLE.
- load_enable while in SEND:
  - Holding register empty: Tx_SR loads into the holding register.
  - Holding register full and the last beat is not being accepted this cycle: the block is dropped and overflow is set.
  - Holding register full and the last beat is accepted the same cycle: holding moves to the shifter and Tx_SR loads into holding. No overflow.
- overflow stays set until clear_ovf. If clear_ovf and a new drop happen in the same cycle, set wins.
- busy = (state==SEND) || holding register full.
- Counter is $clog2(BEATS) bits. It wraps from BEATS-1 to 0 only via the last-beat path.
- All outputs are registered or derived from registered state only. There are no combinational paths from load_enable or Tx_SR to any output.

Optional Feature:
AES_TX_PARITY_EN
- Defined: adds output tx_parity (1 bit) = even parity of tx_data (XOR reduction), valid whenever tx_valid is high and held stable during stalls. tx_parity=0 in reset and in IDLE.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic send: load Tx_SR=128'h00112233445566778899AABBCCDDEEFF with tx_ready=1 held -> tx_valid rises 1 cycle after load; bytes 00,11,...,FF on 16 consecutive cycles; tx_last only on FF; block_done pulses 1 cycle later; busy returns to 0.
- Backpressure: same block, tx_ready toggled 1,0,0,1 repeatedly -> byte order unchanged; tx_data stable across every stall cycle; exactly 16 accepted beats.
- Back-to-back: load block A, then block B during A's beat 3 -> B's byte 0 is valid in the cycle after A's last beat is accepted (no idle cycle); block_done pulses twice; overflow=0.
- Overflow and simultaneity: with tx_ready=0, load A, B and C in turn -> C is dropped and overflow=1. Repeat with C's load_enable coinciding with A's last-beat acceptance -> overflow stays 0 and A, B, C are all sent. Assert clear_ovf -> overflow=0.
- Reset mid-operation: assert rst during beat 7 -> tx_valid=0 and busy=0 immediately; no block_done pulse. After release, a new block is sent from byte 0.
- Parity (with AES_TX_PARITY_EN defined): block of all 8'h01 bytes -> tx_parity=1 on every beat; block of all 8'h03 bytes -> tx_parity=0 on every beat.

Source files
------------

// File: rtl/aes_tx_shifter.sv
// Purpose: captures 128-bit AES result blocks and streams them out MSB byte first over valid/ready.
// Latency: first beat valid 1 cycle after load_enable; back-to-back blocks stream with no bubble.
// Backpressure: beats, tx_last and counter hold while tx_ready is low; one-deep holding register, overflow on drop.
// Optional: define AES_TX_PARITY_EN to add the tx_parity output (even parity of tx_data).
module aes_tx_shifter #(
  parameter int BLOCK_W = 128,
  parameter int BYTE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_enable,
  input  logic [BLOCK_W-1:0] Tx_SR,
  input  logic               tx_ready,
  input  logic               clear_ovf,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_valid,
  output logic               tx_last,
  output logic               block_done,
  output logic               busy,
  output logic               overflow
`ifdef AES_TX_PARITY_EN
  , output logic             tx_parity
`endif
);

  // Beats per block is derived from the two widths and cannot be overridden.
  localparam int BEATS = BLOCK_W / BYTE_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  logic [BLOCK_W-1:0] shifter;
  logic [BLOCK_W-1:0] hold;
  logic               hold_full;
  logic [CW-1:0]      cnt;

  logic accept;
  logic last_acc;
  logic drop;

  // Handshake decode; a drop needs a full holding register that is not being drained this cycle.
  always_comb begin
    accept   = (state == SEND) && tx_ready;
    last_acc = accept && (cnt == LAST_BEAT);
    drop     = (state == SEND) && load_enable && hold_full && !last_acc;
  end

  // Outputs come straight from registered state; nothing depends on load_enable or Tx_SR here.
  assign tx_valid = (state == SEND);
  assign tx_data  = shifter[BLOCK_W-1 -: BYTE_W];
  assign tx_last  = (state == SEND) && (cnt == LAST_BEAT);
  assign busy     = (state == SEND) || hold_full;

`ifdef AES_TX_PARITY_EN
  // Parity follows the held byte, so it is stable through stalls and zero when idle.
  assign tx_parity = tx_valid & (^tx_data);
`endif

  // Sticky overflow flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Send FSM: shifter, beat counter, holding register and the block_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shifter    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      cnt        <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          // The holding register is always empty here, so a load goes straight to the shifter.
          if (load_enable) begin
            shifter <= Tx_SR;
            cnt     <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (last_acc) begin
            block_done <= 1'b1;
            cnt        <= '0;
            if (hold_full) begin
              // Drain the holding register with no bubble; a coincident load refills it.
              shifter   <= hold;
              hold_full <= load_enable;
              if (load_enable) begin
                hold <= Tx_SR;
              end
            end else if (load_enable) begin
              shifter <= Tx_SR;
            end else begin
              // Last shift leaves the shifter all-zero, so tx_data reads 0 while idle.
              shifter <= {shifter[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              state   <= IDLE;
            end
          end else begin
            if (accept) begin
              shifter <= {shifter[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              cnt     <= cnt + 1'b1;
            end
            if (load_enable && !hold_full) begin
              hold      <= Tx_SR;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_tx_shifter.sv
// Purpose: self-checking bench for aes_tx_shifter using a byte scoreboard and a vector table.
// Latency: expects first beat 1 cycle after load and gap-free back-to-back blocks.
// Backpressure: drives tx_ready from 4-cycle patterns and checks stall stability every cycle.
module tb_aes_tx_shifter;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_enable;
  logic [127:0] Tx_SR;
  logic         tx_ready;
  logic         clear_ovf;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_last;
  logic         block_done;
  logic         busy;
  logic         overflow;
`ifdef AES_TX_PARITY_EN
  logic         tx_parity;
`endif

  aes_tx_shifter #(.BLOCK_W(128), .BYTE_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .load_enable(load_enable),
    .Tx_SR(Tx_SR),
    .tx_ready(tx_ready),
    .clear_ovf(clear_ovf),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .block_done(block_done),
    .busy(busy),
    .overflow(overflow)
`ifdef AES_TX_PARITY_EN
    , .tx_parity(tx_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] blk;
    logic [3:0]   pat;
    int           exp_cycles;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int     checks   = 0;
  int     failures = 0;
  int     done_cnt = 0;
  int     acc_cnt  = 0;
  int     kc       = 0;
  logic [3:0] ready_pat = 4'b1111;
  beat_t  exp_q[$];
  vec_t   vecs[4];

  // monitor state
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       pl = 1'b0;
  beat_t      mb;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_block(input logic [127:0] blk);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b.d = blk[127 - 8*i -: 8];
      b.l = (i == 15);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    load_enable = 1'b0;
    clear_ovf   = 1'b0;
    tx_ready    = ready_pat[kc[1:0]];
    kc++;
  endtask

  task automatic load_blk(input logic [127:0] blk, input bit push);
    load_enable = 1'b1;
    Tx_SR       = blk;
    if (push) push_block(blk);
  endtask

  task automatic wait_done(input int n, input int max, output int cycles);
    int seen;
    seen   = 0;
    cycles = 0;
    while (seen < n && cycles < max) begin
      tick();
      cycles++;
      if (block_done) seen++;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("FAIL wait_done: saw %0d block_done pulses, required %0d within %0d cycles", seen, n, max);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (block_done) done_cnt++;
      if (pv && !pr) begin
        chk("stall_valid", 128'(tx_valid), 128'd1);
        chk("stall_data", 128'(tx_data), 128'(pd));
        chk("stall_last", 128'(tx_last), 128'(pl));
      end
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h with no expected beat queued", tx_data);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", 128'(tx_data), 128'(mb.d));
          chk("beat_last", 128'(tx_last), 128'(mb.l));
`ifdef AES_TX_PARITY_EN
          chk("beat_parity", 128'(tx_parity), 128'(^mb.d));
`endif
        end
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      pl = tx_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int a0;
    int d0;

    vecs[0] = '{blk: 128'h00112233445566778899AABBCCDDEEFF, pat: 4'b1111, exp_cycles: 16};
    vecs[1] = '{blk: 128'h00112233445566778899AABBCCDDEEFF, pat: 4'b1001, exp_cycles: 32};
    vecs[2] = '{blk: 128'hDEADBEEF0123456789ABCDEFFEEDC0DE, pat: 4'b0101, exp_cycles: 31};
    vecs[3] = '{blk: 128'hFF00A55A3CC3F00F1122334455667788, pat: 4'b1110, exp_cycles: 22};

    rst         = 1'b1;
    load_enable = 1'b0;
    Tx_SR       = '0;
    tx_ready    = 1'b0;
    clear_ovf   = 1'b0;
    #12;
    chk("rst_tx_data", 128'(tx_data), 128'd0);
    chk("rst_tx_valid", 128'(tx_valid), 128'd0);
    chk("rst_tx_last", 128'(tx_last), 128'd0);
    chk("rst_block_done", 128'(block_done), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
`ifdef AES_TX_PARITY_EN
    chk("rst_parity", 128'(tx_parity), 128'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();

    // Single-block sends under several backpressure patterns.
    foreach (vecs[i]) begin
      ready_pat = vecs[i].pat;
      a0 = acc_cnt;
      chk("idle_valid", 128'(tx_valid), 128'd0);
      load_blk(vecs[i].blk, 1'b1);
      kc = 0;
      tick();
      chk("first_valid", 128'(tx_valid), 128'd1);
      chk("first_byte", 128'(tx_data), 128'(vecs[i].blk[127:120]));
      wait_done(1, 200, cyc);
      chk("vec_cycles", 128'(cyc), 128'(vecs[i].exp_cycles));
      chk("vec_busy_end", 128'(busy), 128'd0);
      chk("vec_beats", 128'(acc_cnt - a0), 128'd16);
      chk("vec_queue_empty", 128'(exp_q.size()), 128'd0);
      tick();
    end

    // Back-to-back: B loads during A's beat 3 and must follow with no idle cycle.
    ready_pat = 4'b1111;
    d0 = done_cnt;
    load_blk(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1);
    kc = 0;
    tick();
    tick();
    tick();
    load_blk(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 1'b1);
    tick();
    wait_done(2, 200, cyc);
    chk("b2b_cycles", 128'(cyc + 3), 128'd32);
    tick();
    chk("b2b_done_count", 128'(done_cnt - d0), 128'd2);
    chk("b2b_overflow", 128'(overflow), 128'd0);
    chk("b2b_queue_empty", 128'(exp_q.size()), 128'd0);

    // Overflow: A in shifter, B in hold, C dropped; clear_ovf in the same cycle loses.
    ready_pat = 4'b0000;
    load_blk(128'h0A0A0A0A0A0A0A0A0A0A0A0A0A0A0A0A, 1'b1);
    tick();
    load_blk(128'h0B0B0B0B0B0B0B0B0B0B0B0B0B0B0B0B, 1'b1);
    tick();
    load_blk(128'h0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C, 1'b0);
    clear_ovf = 1'b1;
    tick();
    chk("ovf_set", 128'(overflow), 128'd1);
    chk("ovf_busy", 128'(busy), 128'd1);
    ready_pat = 4'b1111;
    wait_done(2, 200, cyc);
    tick();
    chk("ovf_sticky", 128'(overflow), 128'd1);
    chk("ovf_queue_empty", 128'(exp_q.size()), 128'd0);
    clear_ovf = 1'b1;
    tick();
    chk("ovf_cleared", 128'(overflow), 128'd0);

    // C's load coincides with A's last-beat acceptance: nothing dropped.
    load_blk(128'h1A1A1A1A1A1A1A1A1A1A1A1A1A1A1A1A, 1'b1);
    kc = 0;
    tick();
    load_blk(128'h1B1B1B1B1B1B1B1B1B1B1B1B1B1B1B1B, 1'b1);
    tick();
    repeat (14) tick();
    load_blk(128'h1C1C1C1C1C1C1C1C1C1C1C1C1C1C1C1C, 1'b1);
    tick();
    chk("sim_overflow", 128'(overflow), 128'd0);
    chk("sim_a_done", 128'(block_done), 128'd1);
    wait_done(2, 200, cyc);
    chk("sim_cycles", 128'(cyc), 128'd32);
    chk("sim_overflow_end", 128'(overflow), 128'd0);
    chk("sim_queue_empty", 128'(exp_q.size()), 128'd0);
    tick();

    // Reset during beat 7 discards the block immediately.
    load_blk(128'h202122232425262728292A2B2C2D2E2F, 1'b1);
    kc = 0;
    tick();
    repeat (7) tick();
    chk("mid_beat7", 128'(tx_data), 128'h27);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(tx_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_data", 128'(tx_data), 128'd0);
    exp_q.delete();
    d0 = done_cnt;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_no_done", 128'(done_cnt - d0), 128'd0);
    chk("mid_idle_valid", 128'(tx_valid), 128'd0);
    load_blk(128'h303132333435363738393A3B3C3D3E3F, 1'b1);
    kc = 0;
    tick();
    chk("post_rst_byte0", 128'(tx_data), 128'h30);
    wait_done(1, 200, cyc);
    chk("post_rst_cycles", 128'(cyc), 128'd16);
    chk("post_rst_queue_empty", 128'(exp_q.size()), 128'd0);
    tick();

`ifdef AES_TX_PARITY_EN
    // Odd-weight bytes give parity 1, even-weight bytes give parity 0.
    chk("par_idle", 128'(tx_parity), 128'd0);
    load_blk({16{8'h01}}, 1'b1);
    kc = 0;
    tick();
    chk("par_ones", 128'(tx_parity), 128'd1);
    wait_done(1, 200, cyc);
    tick();
    load_blk({16{8'h03}}, 1'b1);
    kc = 0;
    tick();
    chk("par_threes", 128'(tx_parity), 128'd0);
    wait_done(1, 200, cyc);
    chk("par_queue_empty", 128'(exp_q.size()), 128'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
